// File: rtl/range_fetch_pkg.sv
// range_fetch_pkg
//   Shared definitions for the range fetch controller: FSM state encoding,
//   default line geometry and helpers that split an element index into a
//   line index and a lane within that line.
package range_fetch_pkg;

   // Default geometry: 512-bit lines of 64-bit elements.
   localparam int LINE_WIDTH_D = 512;
   localparam int ELEM_WIDTH_D = 64;
   localparam int EPL          = LINE_WIDTH_D / ELEM_WIDTH_D;
   localparam int LANE_W       = $clog2(EPL);
   localparam int LB           = LINE_WIDTH_D / 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ADDR = 2'd1;
   localparam state_t ST_DATA = 2'd2;
   localparam state_t ST_EMIT = 2'd3;

   // Line holding element idx (elements per line = 2**lane_w).
   function automatic logic [63:0] line_of(input logic [63:0] idx, input int lane_w);
      return idx >> lane_w;
   endfunction

   // Position of element idx inside its line.
   function automatic logic [63:0] lane_of(input logic [63:0] idx, input int lane_w);
      return idx & ((64'd1 << lane_w) - 64'd1);
   endfunction

endpackage

// File: rtl/range_fetch_ctrl_unpacker.sv
// line_unpacker
//   Holds one captured memory line and walks it lane by lane from a first
//   lane to a last lane.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_load         capture i_line and the lane window
//   i_line         full memory line
//   i_first_lane   first lane to present
//   i_last_lane    final lane to present
//   i_adv          consumer took the current lane
//   o_data         element at the current lane
//   o_at_last      current lane is the last lane of the window
//   o_line_empty   every lane of the window has been consumed
module line_unpacker #(
   parameter int LINE_WIDTH = 512,
   parameter int ELEM_WIDTH = 64,
   localparam int EPL = LINE_WIDTH / ELEM_WIDTH,
   localparam int LW  = (EPL > 1) ? $clog2(EPL) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic [LINE_WIDTH-1:0] i_line,
   input  logic [LW-1:0]         i_first_lane,
   input  logic [LW-1:0]         i_last_lane,
   input  logic                  i_adv,
   output logic [ELEM_WIDTH-1:0] o_data,
   output logic                  o_at_last,
   output logic                  o_line_empty
);

   // Lane k of the line sits at bits [ELEM_WIDTH*k +: ELEM_WIDTH].
   logic [EPL-1:0][ELEM_WIDTH-1:0] r_line;
   logic [LW-1:0]                  r_lane;
   logic [LW-1:0]                  r_last;
   logic                           r_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_line  <= '0;
         r_lane  <= '0;
         r_last  <= '0;
         r_empty <= 1'b1;
      end else if (i_load) begin
         r_line  <= i_line;
         r_lane  <= i_first_lane;
         r_last  <= i_last_lane;
         r_empty <= 1'b0;
      end else if (i_adv && !r_empty) begin
         if (r_lane == r_last) r_empty <= 1'b1;
         else                  r_lane  <= r_lane + 1'b1;
      end
   end

   assign o_data       = r_line[r_lane];
   assign o_at_last    = (r_lane == r_last);
   assign o_line_empty = r_empty;

endmodule

// File: rtl/range_fetch_ctrl.sv
// range_fetch_ctrl
//   Reads the element range [start, start+count) of an array starting at a
//   line-aligned byte address, one memory line at a time, and streams the
//   elements out with valid/ready and a last flag. At most one line read is
//   outstanding.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              range request handshake (ready in IDLE)
//   req_base/req_start/req_count     array base, first element, element count
//   mem_arvalid/mem_arready/araddr   line read request
//   mem_rvalid/mem_rready/mem_rdata  line read data
//   out_valid/out_ready/out_data     element stream
//   out_last                         final element of the request
//   done                             one-cycle pulse when a request completes
module range_fetch_ctrl
   import range_fetch_pkg::*;
#(
   parameter int LINE_WIDTH = 512,
   parameter int ELEM_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_base,
   input  logic [LEN_WIDTH-1:0]  req_start,
   input  logic [LEN_WIDTH-1:0]  req_count,
   output logic                  mem_arvalid,
   input  logic                  mem_arready,
   output logic [ADDR_WIDTH-1:0] mem_araddr,
   input  logic                  mem_rvalid,
   output logic                  mem_rready,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ELEM_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  done
);

   localparam int EPL_L = LINE_WIDTH / ELEM_WIDTH;
   localparam int LW    = (EPL_L > 1) ? $clog2(EPL_L) : 1;
   localparam int LB_SH = $clog2(LINE_WIDTH / 8);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [LEN_WIDTH-1:0]  r_line_idx;
   logic [LEN_WIDTH-1:0]  r_remaining;
   logic [LW-1:0]         r_lane0;
   logic                  r_first;
   logic                  r_done;

   logic                  w_req_hs;
   logic                  w_r_hs;
   logic                  w_out_hs;
   logic                  w_at_last;
   logic                  w_line_empty;
   logic [LW-1:0]         w_first_lane;
   logic [LW-1:0]         w_last_lane;
   logic [LEN_WIDTH-1:0]  w_span;

   assign req_ready   = (r_state == ST_IDLE);
   assign mem_arvalid = (r_state == ST_ADDR);
   assign mem_rready  = (r_state == ST_DATA);
   assign out_valid   = (r_state == ST_EMIT) && !w_line_empty;
   // remaining==1 can only occur on the window's last lane, so this also
   // marks the final element of the whole request.
   assign out_last    = out_valid && (r_remaining == LEN_WIDTH'(1));
   assign done        = r_done;

   // Byte address wraps modulo 2**ADDR_WIDTH.
   assign mem_araddr  = r_base + (ADDR_WIDTH'(r_line_idx) << LB_SH);

   assign w_req_hs = req_valid && req_ready;
   assign w_r_hs   = mem_rvalid && mem_rready;
   assign w_out_hs = out_valid && out_ready;

   // Only the first line of a request starts mid-line; the window ends at the
   // line end or where the remaining count runs out, whichever comes first.
   assign w_first_lane = r_first ? r_lane0 : '0;
   assign w_span       = LEN_WIDTH'(EPL_L) - LEN_WIDTH'(w_first_lane);
   assign w_last_lane  = (r_remaining >= w_span) ? LW'(EPL_L - 1)
                       : LW'(LEN_WIDTH'(w_first_lane) + r_remaining - LEN_WIDTH'(1));

   line_unpacker #(
      .LINE_WIDTH (LINE_WIDTH),
      .ELEM_WIDTH (ELEM_WIDTH)
   ) u_unpack (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_load       (w_r_hs),
      .i_line       (mem_rdata),
      .i_first_lane (w_first_lane),
      .i_last_lane  (w_last_lane),
      .i_adv        (w_out_hs),
      .o_data       (out_data),
      .o_at_last    (w_at_last),
      .o_line_empty (w_line_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_base      <= '0;
         r_line_idx  <= '0;
         r_remaining <= '0;
         r_lane0     <= '0;
         r_first     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req_hs) begin
                  r_base      <= req_base;
                  r_line_idx  <= LEN_WIDTH'(line_of(64'(req_start), LW));
                  r_lane0     <= LW'(lane_of(64'(req_start), LW));
                  r_remaining <= req_count;
                  r_first     <= 1'b1;
                  // An empty range completes without touching memory.
                  if (req_count == '0) r_done  <= 1'b1;
                  else                 r_state <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (mem_arready) r_state <= ST_DATA;
            end
            ST_DATA: begin
               if (w_r_hs) begin
                  r_first <= 1'b0;
                  r_state <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (w_out_hs) begin
                  r_remaining <= r_remaining - LEN_WIDTH'(1);
                  if (w_at_last) begin
                     if (r_remaining == LEN_WIDTH'(1)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                     end else begin
                        r_line_idx <= r_line_idx + LEN_WIDTH'(1);
                        r_state    <= ST_ADDR;
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_range_fetch_ctrl.sv
module tb_range_fetch_ctrl;

   localparam logic [31:0] MEM_BASE = 32'h1000;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_base;
   logic [31:0]   req_start;
   logic [31:0]   req_count;
   logic          mem_arvalid;
   logic          mem_arready;
   logic [31:0]   mem_araddr;
   logic          mem_rvalid;
   logic          mem_rready;
   logic [511:0]  mem_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_data;
   logic          out_last;
   logic          done;

   range_fetch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_base    (req_base),
      .req_start   (req_start),
      .req_count   (req_count),
      .mem_arvalid (mem_arvalid),
      .mem_arready (mem_arready),
      .mem_araddr  (mem_araddr),
      .mem_rvalid  (mem_rvalid),
      .mem_rready  (mem_rready),
      .mem_rdata   (mem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ar_q[$];

   int n_cmp      = 0;
   int n_bad      = 0;
   int done_cnt   = 0;
   int out_hs_cnt = 0;
   int ar_cnt     = 0;
   bit rnd_ready  = 1'b0;
   int ar_delay   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Memory contents: element k of the array at MEM_BASE holds 100+k.
   function automatic logic [511:0] mk_line(input logic [31:0] addr);
      logic [511:0] l;
      int           lidx;
      lidx = int'((addr - MEM_BASE) >> 6);
      for (int k = 0; k < 8; k++) l[k*64 +: 64] = 64'(100 + lidx*8 + k);
      return l;
   endfunction

   // Memory model, ready drivers and output monitor. Inputs change on the
   // falling edge; handshakes are sampled 1ns before the next rising edge.
   initial begin : mon
      bit          pend;
      logic [31:0] pend_addr;
      int          arw;
      bit          p_ar_st, p_out_st, p_done;
      logic [31:0] p_addr;
      logic [63:0] p_data;
      exp_t        e;
      pend = 0; pend_addr = '0; arw = 0;
      p_ar_st = 0; p_out_st = 0; p_done = 0; p_addr = '0; p_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mem_rvalid  = 1'b0;
            mem_arready = (ar_delay == 0);
            pend = 0; arw = 0; p_ar_st = 0; p_out_st = 0; p_done = 0;
            continue;
         end
         mem_rvalid  = pend;
         mem_rdata   = pend ? mk_line(pend_addr) : '0;
         mem_arready = (ar_delay == 0) || (arw >= ar_delay);
         out_ready   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #4;
         if (!rst_n) continue;
         // read address channel
         if (mem_arvalid && mem_arready) begin
            ar_cnt++;
            if (ar_q.size() == 0) chk("ar_extra", 64'(mem_araddr), 64'h0);
            else                  chk("ar_addr", 64'(mem_araddr), 64'(ar_q.pop_front()));
            pend = 1; pend_addr = mem_araddr; arw = 0; p_ar_st = 0;
         end else begin
            if (p_ar_st && mem_arvalid) chk("ar_hold", 64'(mem_araddr), 64'(p_addr));
            if (mem_arvalid) arw++;
            p_ar_st = mem_arvalid;
            p_addr  = mem_araddr;
         end
         if (mem_rvalid && mem_rready) pend = 0;
         // element stream
         if (out_last) chk("last_wo_valid", 64'(out_valid), 64'h1);
         if (p_out_st && out_valid) chk("out_hold", out_data, p_data);
         if (out_valid && out_ready) begin
            out_hs_cnt++;
            if (exp_q.size() == 0) chk("out_extra", out_data, 64'hdead);
            else begin
               e = exp_q.pop_front();
               chk("out_data", out_data, e.data);
               chk("out_last", 64'(out_last), 64'(e.last));
            end
         end
         p_out_st = out_valid && !out_ready;
         p_data   = out_data;
         if (done) begin
            done_cnt++;
            chk("done_pulse", 64'(p_done), 64'h0);
         end
         p_done = done;
      end
   end

   task automatic send_req(input logic [31:0] base, input int start, input int count,
                           input bit busy_chk);
      int waited;
      exp_t e;
      for (int i = 0; i < count; i++) begin
         e.data = 64'(100 + start + i);
         e.last = (i == count - 1);
         exp_q.push_back(e);
      end
      if (count > 0)
         for (int l = start / 8; l <= (start + count - 1) / 8; l++)
            ar_q.push_back(base + 32'(l * 64));
      @(negedge clk);
      req_valid = 1'b1;
      req_base  = base;
      req_start = 32'(start);
      req_count = 32'(count);
      waited    = 0;
      while (!req_ready && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) chk("req_timeout", 64'h0, 64'h1);
      else if (busy_chk) begin
         chk("busy_wait", 64'(waited > 0), 64'h1);
         chk("rdy_at_done", 64'(done), 64'h1);
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("arv_rise", 64'(mem_arvalid), 64'(count != 0));
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      int d0, a0, h0, n;
      rst_n = 1'b0; req_valid = 1'b0; req_base = '0; req_start = '0; req_count = '0;
      out_ready = 1'b1; mem_arready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'h1);
      chk("rst_arvalid",   64'(mem_arvalid), 64'h0);
      chk("rst_rready",    64'(mem_rready), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_done",      64'(done), 64'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single line, mid-line window
      d0 = done_cnt; a0 = ar_cnt;
      send_req(MEM_BASE, 3, 4, 0);
      wait_done(d0 + 1);
      chk("t1_ars", 64'(ar_cnt - a0), 64'd1);
      chk("t1_q", 64'(exp_q.size()), 64'd0);

      // crosses a line boundary
      d0 = done_cnt; a0 = ar_cnt;
      send_req(MEM_BASE, 6, 5, 0);
      wait_done(d0 + 1);
      chk("t2_ars", 64'(ar_cnt - a0), 64'd2);
      chk("t2_q", 64'(exp_q.size()), 64'd0);

      // empty range
      d0 = done_cnt; a0 = ar_cnt;
      send_req(MEM_BASE, 5, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t3_ready", 64'(req_ready), 64'h1);
         chk("t3_arvalid", 64'(mem_arvalid), 64'h0);
      end
      chk("t3_done", 64'(done_cnt - d0), 64'd1);
      chk("t3_ars", 64'(ar_cnt - a0), 64'd0);

      // back-pressure on both sides
      rnd_ready = 1'b1; ar_delay = 5;
      d0 = done_cnt; a0 = ar_cnt;
      send_req(MEM_BASE, 8, 16, 0);
      wait_done(d0 + 1);
      chk("t4_ars", 64'(ar_cnt - a0), 64'd2);
      chk("t4_q", 64'(exp_q.size()), 64'd0);
      rnd_ready = 1'b0; ar_delay = 0;

      // reset in the middle of a request
      h0 = out_hs_cnt;
      send_req(MEM_BASE, 0, 8, 0);
      n = 0;
      while (out_hs_cnt < h0 + 2 && n < 500) begin
         @(posedge clk); #2;
         n++;
      end
      chk("t5_two_out", 64'(out_hs_cnt - h0), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("t5_out_valid", 64'(out_valid), 64'h0);
      chk("t5_out_data",  out_data, 64'h0);
      chk("t5_out_last",  64'(out_last), 64'h0);
      chk("t5_arvalid",   64'(mem_arvalid), 64'h0);
      chk("t5_araddr",    64'(mem_araddr), 64'h0);
      chk("t5_rready",    64'(mem_rready), 64'h0);
      chk("t5_done",      64'(done), 64'h0);
      chk("t5_req_ready", 64'(req_ready), 64'h1);
      exp_q.delete();
      ar_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt;
      send_req(MEM_BASE, 0, 1, 0);
      wait_done(d0 + 1);
      chk("t5_q", 64'(exp_q.size()), 64'd0);

      // second request waits while the first is in flight
      d0 = done_cnt; a0 = ar_cnt;
      send_req(MEM_BASE, 0, 3, 0);
      send_req(MEM_BASE, 10, 4, 1);
      wait_done(d0 + 2);
      chk("t6_ars", 64'(ar_cnt - a0), 64'd2);
      chk("t6_q", 64'(exp_q.size()), 64'd0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/range_fetch_ctrl.md
Name: range_fetch_ctrl

Overview:
- Sequences memory line reads for a contiguous element range [start, start+count) of an edge or offset array.
- Fetches each 512-bit line once and unpacks it into a 64-bit element stream with valid/ready and a last flag.
- Sits between the PageRank vertex/edge engines, which issue range requests, and the memory read port.
- Holds exactly one outstanding line read at a time.

Parameters:
- LINE_WIDTH, 512: memory read data width in bits.
- ELEM_WIDTH, 64: element width in bits; LINE_WIDTH/ELEM_WIDTH must be a power of two.
- ADDR_WIDTH, 32: byte address width.
- LEN_WIDTH, 32: width of element index and count.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  range request valid.
- req_ready  out  1  high only in IDLE.
- req_base  in  ADDR_WIDTH  byte address of element 0; line-aligned.
- req_start  in  LEN_WIDTH  first element index.
- req_count  in  LEN_WIDTH  number of elements.
- mem_arvalid  out  1  line read request.
- mem_arready  in  1  memory accepts request.
- mem_araddr  out  ADDR_WIDTH  line byte address.
- mem_rvalid  in  1  line data valid.
- mem_rready  out  1  high only in DATA.
- mem_rdata  in  LINE_WIDTH  line data; element k occupies bits [ELEM_WIDTH*k +: ELEM_WIDTH].
- out_valid  out  1  element valid.
- out_ready  in  1  consumer accepts element.
- out_data  out  ELEM_WIDTH  element.
- out_last  out  1  final element of the request.
- done  out  1  one-cycle pulse when a request completes.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0 except req_ready=1.
  - Internal counters and line register cleared.
  - A reset mid-request abandons it; a late mem_rvalid after reset is ignored (rready=0).
- Derived quantities:
  - EPL = LINE_WIDTH/ELEM_WIDTH.
  - LB = LINE_WIDTH/8 bytes per line.
  - Line index = start >> log2(EPL); lane = start mod EPL.
  - Address arithmetic is modulo 2^ADDR_WIDTH.
- IDLE:
  - On req_valid&&req_ready, latch base, start, count.
  - If count==0: pulse done next cycle, stay IDLE, no memory traffic.
  - Otherwise go to ADDR; mem_arvalid rises exactly 1 cycle after acceptance.
- ADDR:
  - mem_arvalid=1; mem_araddr = base + line_idx*LB, held stable until mem_arready.
  - On handshake go to DATA.
- DATA:
  - mem_rready=1; on mem_rvalid capture the line into the unpacker.
  - first_lane = lane for the first line of a request, else 0.
  - last_lane = min(EPL-1, first_lane + remaining - 1).
  - Go to EMIT.
- EMIT:
  - out_valid=1; out_data = current lane, held stable while out_ready=0.
  - On each handshake: decrement remaining, advance lane.
  - On the last_lane handshake with remaining becoming 0: out_last=1 on that element; go to IDLE with done pulse the following cycle.
  - On the last_lane handshake otherwise: line_idx+1, go to ADDR.
- req_ready is never high outside IDLE; requests presented while busy wait.
- The first element reaches out_valid no earlier than 3 cycles after acceptance, given arready and rvalid both high immediately.
- A request spanning N lines issues exactly N AR handshakes, in ascending address order.
- out_last is asserted only together with out_valid.

Decomposition:
- Package range_fetch_pkg:
  - state enum {IDLE, ADDR, DATA, EMIT}.
  - EPL, LANE_W=$clog2(EPL), LB constants.
  - Helpers for line index and lane extraction.
- Sub-module line_unpacker:
  - Holds the captured line, current lane and last_lane.
  - Provides out_data and a line_empty flag.
  - Parameterised by LINE_WIDTH and ELEM_WIDTH.

Test Plan:
- base=0x1000, start=3, count=4, lines hold element k = 100+k → one AR at 0x1000; out_data 103,104,105,106; out_last only on 106; done 1 cycle later.
- base=0x1000, start=6, count=5 → ARs at 0x1000 then 0x1040; outputs 106,107,108,109,110; out_last on 110.
- count=0 → no mem_arvalid ever; done pulses once; req_ready stays 1.
- start=8, count=16 with out_ready random 50% and arready delayed 5 cycles → ARs at 0x1040 and 0x1080 only; araddr and out_data stable during stalls; 16 elements in order.
- rst_n pulsed low in EMIT after 2 of 8 elements → all outputs 0 immediately; a following request start=0, count=1 returns element 100 with out_last.
- Second req_valid held while busy → req_ready=0 until the first request's done; the second request is then accepted with no lost or duplicated elements.
